pulse_train_checker: RTL
========================

Name: pulse_train_checker

Overview:
- Receive-side partner of the periodic output timer: monitors the pulse train it emits and checks it against the expected high time and period.
- Checks every period and declares lock after a run of good periods.
- While locked, rebuilds the transmitter's phase count and low-start strobe.
- Sits on the consumer side of the timer's `o` line, same clock domain, no synchroniser.

Parameters:
- HIGH_CYCLES, 16, expected high time of each pulse in clk cycles.
- PERIOD_CYCLES, 24, expected rise-to-rise period in clk cycles.
- LOCK_PERIODS, 3, consecutive good periods needed to assert locked.
- CNT_W, 6, width of the internal cycle counter; must satisfy 2^CNT_W > PERIOD_CYCLES+1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  synchronous enable; low forces IDLE and clears all state.
- sig  input  1  monitored pulse train (timer output).
- locked  output  1  registered; high while the train is verified.
- err  output  1  registered one-cycle error strobe.
- err_code  output  2  registered code of the last error: 01 high-length, 10 period, 11 timeout; holds until the next error or clear.
- phase  output  5  registered; cycles since last rise (0..PERIOD_CYCLES-1) while locked, else 0.
- low_start  output  1  registered one-cycle strobe when sig falls while locked.
- high_len  output  CNT_W  registered; last measured high time.
- period_len  output  CNT_W  registered; last measured period.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - sig_d, cnt, good_cnt, high_ok, locked, err, err_code, phase, low_start, high_len and period_len all 0.
- Edge detect:
  - sig_d is sig delayed one clk.
  - rise = sig & ~sig_d; fall = ~sig & sig_d; both combinational.
  - rise and fall are mutually exclusive.
- Counter:
  - cnt_next = 0 on rise, otherwise cnt+1, saturating at all-ones.
  - For a rise sampled at cycle t0, cnt = k-1 at cycle t0+k.
- Measurements:
  - On fall in TRACK: high_len <= cnt+1.
  - On rise in TRACK: period_len <= cnt+1.
- States:
  - IDLE: entered on reset or en=0; all outputs and counters cleared each cycle, err_code included. Leaves for SEARCH when en=1.
  - SEARCH: waits for rise. On rise go to TRACK with cnt<=0, good_cnt<=0, high_ok<=0. No errors are reported in SEARCH.
  - TRACK, on fall:
    - high_ok <= (cnt+1 == HIGH_CYCLES).
    - If the check fails: err=1, err_code=01.
    - If locked: low_start=1 in the next cycle, regardless of the high-length check.
  - TRACK, on rise:
    - Period is good when cnt+1 == PERIOD_CYCLES and high_ok=1.
    - Good period: good_cnt increments, saturating at LOCK_PERIODS; locked<=1 once good_cnt+1 >= LOCK_PERIODS.
    - Bad period: good_cnt<=0 and locked<=0. err=1 with err_code=10 on period mismatch; a high-length failure was already reported at the fall.
    - high_ok <= 0 for the new period. State stays TRACK.
  - TRACK, timeout: cnt+1 > PERIOD_CYCLES with no rise → err=1, err_code=11, locked=0, good_cnt=0, go to SEARCH. This covers sig stuck high or stuck low.
- Any error in TRACK clears locked in the same update.
- phase:
  - While locked, phase <= cnt_next, truncated to 5 bits.
  - phase equals the transmitter's phase count delayed one cycle; it reads 0 in the cycle after each rise.
  - Not locked: phase=0.
- Latency: every registered output updates one clk after the sig sample that caused it.
- en deasserted mid-period: next cycle is IDLE with all outputs 0; re-enable restarts from SEARCH.
- First rise after SEARCH only starts measurement; no period is checked on it.

Decomposition:
- Shared package:
  - state encoding localparams IDLE/SEARCH/TRACK.
  - err_code constants ERR_HIGH=2'b01, ERR_PERIOD=2'b10, ERR_TIMEOUT=2'b11.
  - Default HIGH_CYCLES/PERIOD_CYCLES, shared with the timer so both ends agree.
- One natural sub-module: edge_detect (sig_d flop plus rise/fall decode).
- FSM, counter and checks stay in pulse_train_checker.

Test Plan:
- Timer-shaped train: sig high 16, low 8, repeating, en=1 → high_len=16 and period_len=24 after the first full period.
  - locked rises one cycle after the 4th rise (3rd complete period); err never asserts.
  - While locked, low_start is high in the cycle after each fall and phase counts 0..23.
- Locked, then one pulse with high time 15 → err=1 with err_code=01 one cycle after the fall.
  - At the next rise: locked=0, good_cnt=0; a further 3 good periods relock.
- Locked, then one period of 25 (low time 9) → err=1 and err_code=10 one cycle after the late rise; locked=0, state stays TRACK.
- sig held low after a fall → err=1 and err_code=11 once cnt+1 reaches 25; state SEARCH, locked=0.
  - A later good train relocks after 3 periods.
- en dropped to 0 mid-high while locked → next cycle all outputs 0, state IDLE.
  - en back to 1 → SEARCH; no err on the partial first pulse.
- rst asserted low mid-period → all outputs 0 immediately, without waiting for clk; after release, behaviour as from power-up.

Source files
------------

// File: rtl/pulse_train_checker_pkg.sv
// -----------------------------------------------------------------------------
// pulse_train_checker_pkg
//   Shared definitions for the pulse train checker and its edge detector.
//   The default timing values are the same ones the periodic output timer
//   uses, so both ends of the link agree on the expected waveform.
//   Contents: FSM state encoding, error codes, default timing parameters.
// -----------------------------------------------------------------------------
package pulse_train_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HIGH    = 2'b01;
  localparam logic [1:0] ERR_PERIOD  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int DEFAULT_HIGH_CYCLES   = 16;
  localparam int DEFAULT_PERIOD_CYCLES = 24;
  localparam int DEFAULT_LOCK_PERIODS  = 3;
  localparam int DEFAULT_CNT_W         = 6;

  // Width of the rebuilt transmitter phase count.
  localparam int PHASE_W = 5;

endpackage

// File: rtl/pulse_train_checker_edge_detect.sv
// -----------------------------------------------------------------------------
// pulse_train_checker_edge_detect
//   Delays the monitored signal by one clock and decodes its rising and
//   falling edges. The delay flop runs whenever the block is out of reset,
//   independent of the checker's enable, so re-enabling in the middle of a
//   high pulse does not produce a false rise.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-low reset
//     sig  - monitored pulse train
//     rise - combinational, sig high now and low on the previous cycle
//     fall - combinational, sig low now and high on the previous cycle
// -----------------------------------------------------------------------------
module pulse_train_checker_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_d_reg <= 1'b0;
    end else begin
      sig_d_reg <= sig;
    end
  end

  assign rise = sig & ~sig_d_reg;
  assign fall = ~sig & sig_d_reg;

endmodule

// File: rtl/pulse_train_checker.sv
// -----------------------------------------------------------------------------
// pulse_train_checker
//   Monitors the pulse train produced by the periodic output timer and checks
//   each pulse's high time and each rise-to-rise period. After LOCK_PERIODS
//   consecutive good periods it declares lock and, while locked, rebuilds the
//   transmitter's phase count and low-start strobe.
//   Ports:
//     clk        - clock, all logic on the rising edge
//     rst        - asynchronous active-low reset
//     en         - synchronous enable; low forces IDLE and clears everything
//     sig        - monitored pulse train
//     locked     - high while the train is verified
//     err        - one-cycle error strobe
//     err_code   - code of the last error (high-length / period / timeout)
//     phase      - cycles since the last rise while locked, else 0
//     low_start  - one-cycle strobe after a fall while locked
//     high_len   - last measured high time
//     period_len - last measured period
// -----------------------------------------------------------------------------
module pulse_train_checker
  import pulse_train_checker_pkg::*;
#(
  parameter int HIGH_CYCLES   = DEFAULT_HIGH_CYCLES,
  parameter int PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int LOCK_PERIODS  = DEFAULT_LOCK_PERIODS,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sig,
  output logic               locked,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [PHASE_W-1:0] phase,
  output logic               low_start,
  output logic [CNT_W-1:0]   high_len,
  output logic [CNT_W-1:0]   period_len
);

  localparam int GOOD_W = $clog2(LOCK_PERIODS + 1);

  // Comparisons are done on cnt+1 in one extra bit so a saturated counter
  // can never wrap into a false match.
  localparam logic [CNT_W:0]  HIGH_LEN_EXP   = (CNT_W + 1)'(HIGH_CYCLES);
  localparam logic [CNT_W:0]  PERIOD_LEN_EXP = (CNT_W + 1)'(PERIOD_CYCLES);
  localparam logic [GOOD_W:0] LOCK_CNT       = (GOOD_W + 1)'(LOCK_PERIODS);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W:0]    cnt_plus1;
  logic [GOOD_W-1:0] good_cnt_reg;
  logic [GOOD_W-1:0] good_cnt_sat;
  logic [GOOD_W:0]   good_plus1;
  logic              high_ok_reg;
  logic              rise;
  logic              fall;
  logic              high_good;
  logic              period_len_ok;
  logic              period_good;
  logic              timeout;
  logic              lock_reached;
  logic              locked_next;

  pulse_train_checker_edge_detect u_edge_detect (
    .clk  (clk),
    .rst  (rst),
    .sig  (sig),
    .rise (rise),
    .fall (fall)
  );

  // Counter restarts on every rise so cnt = k-1 k cycles after the rise;
  // cnt+1 is therefore the number of cycles since the rise was sampled.
  assign cnt_plus1     = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
  assign cnt_next      = rise ? '0 : ((&cnt_reg) ? cnt_reg : cnt_plus1[CNT_W-1:0]);

  assign high_good     = (cnt_plus1 == HIGH_LEN_EXP);
  assign period_len_ok = (cnt_plus1 == PERIOD_LEN_EXP);
  assign period_good   = period_len_ok && high_ok_reg;
  assign timeout       = (cnt_plus1 > PERIOD_LEN_EXP);

  assign good_plus1    = {1'b0, good_cnt_reg} + (GOOD_W + 1)'(1);
  assign lock_reached  = (good_plus1 >= LOCK_CNT);
  assign good_cnt_sat  = lock_reached ? LOCK_CNT[GOOD_W-1:0] : good_plus1[GOOD_W-1:0];

  // Next lock state is needed both for the locked flop and for phase, so
  // phase already reads 0 in the first locked cycle after a rise.
  always_comb begin
    locked_next = 1'b0;
    if (en && (state_reg == TRACK)) begin
      if (rise) begin
        locked_next = period_good && lock_reached;
      end else if (timeout) begin
        locked_next = 1'b0;
      end else if (fall) begin
        locked_next = locked && high_good;
      end else begin
        locked_next = locked;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      good_cnt_reg <= '0;
      high_ok_reg  <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      phase        <= '0;
      low_start    <= 1'b0;
      high_len     <= '0;
      period_len   <= '0;
    end else if (!en) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      good_cnt_reg <= '0;
      high_ok_reg  <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      phase        <= '0;
      low_start    <= 1'b0;
      high_len     <= '0;
      period_len   <= '0;
    end else begin
      // Strobes default low; lock and phase follow the combinational decision.
      err       <= 1'b0;
      low_start <= 1'b0;
      locked    <= locked_next;
      phase     <= locked_next ? PHASE_W'(cnt_next) : '0;

      case (state_reg)
        IDLE: begin
          cnt_reg      <= '0;
          good_cnt_reg <= '0;
          high_ok_reg  <= 1'b0;
          err_code     <= ERR_NONE;
          high_len     <= '0;
          period_len   <= '0;
          state_reg    <= SEARCH;
        end

        SEARCH: begin
          // The first rise only starts the measurement; nothing is checked.
          cnt_reg <= cnt_next;
          if (rise) begin
            good_cnt_reg <= '0;
            high_ok_reg  <= 1'b0;
            state_reg    <= TRACK;
          end
        end

        TRACK: begin
          cnt_reg <= cnt_next;
          if (rise) begin
            period_len  <= cnt_plus1[CNT_W-1:0];
            high_ok_reg <= 1'b0;
            if (period_good) begin
              good_cnt_reg <= good_cnt_sat;
            end else begin
              good_cnt_reg <= '0;
              // A bad high time was already flagged at the fall.
              if (!period_len_ok) begin
                err      <= 1'b1;
                err_code <= ERR_PERIOD;
              end
            end
          end else if (timeout) begin
            // No rise within a period: sig is stuck, drop back to searching.
            err          <= 1'b1;
            err_code     <= ERR_TIMEOUT;
            good_cnt_reg <= '0;
            state_reg    <= SEARCH;
          end else if (fall) begin
            high_len    <= cnt_plus1[CNT_W-1:0];
            high_ok_reg <= high_good;
            if (!high_good) begin
              err      <= 1'b1;
              err_code <= ERR_HIGH;
            end
            // Low-start follows the transmitter even on a short/long pulse.
            if (locked) begin
              low_start <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
